bcd_display_seq: RTL and testbench
==================================

Name: bcd_display_seq

Overview:
Parametrised successor to the combinational-divide display register. Converts an unsigned binary value to packed BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock, so no divider/modulo logic is needed. Provides a busy/valid handshake, a one-deep pending slot, overflow saturation and a leading-zero blanking mask for the seven-segment scan driver. Sits between the CPU result/PC path and the display multiplexer.

Parameters:
BIN_W, 14, width of binary input num (>=1)
DIGITS, 4, number of BCD digits produced (>=1)
BLANK_LZ, 1, 1 = generate leading-zero blank mask; 0 = blank held all-zero

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; one clock and reset for the whole block
we  in  1  load request; num sampled on the edge where we=1
num  in  BIN_W  unsigned binary value to convert
BCD  out  4*DIGITS  registered packed BCD; digit i at [4i+3:4i], digit 0 = units
busy  out  1  conversion in progress
valid  out  1  one-cycle pulse: BCD/overflow/blank just updated
overflow  out  1  registered; last result exceeded 10^DIGITS-1
blank  out  DIGITS  registered; bit i=1 -> digit i is a leading zero, suppress it

Behaviour:
- Reset (sync, priority over everything): BCD=0, valid=0, busy=0, overflow=0, pending cleared, engine to IDLE; blank = all ones except bit 0 when BLANK_LZ=1, else 0. Reset mid-conversion aborts it; no valid pulse, outputs hold reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: we=1 at edge N -> capture num into shift register, clear scratch/overflow-sticky, bit counter=BIN_W, go SHIFT. busy=1 from cycle N+1.
- SHIFT: each cycle, every scratch digit >=5 gets +3, then {scratch,shift} shifts left 1; counter decrements; after BIN_W shifts go DONE. Carry out of scratch top bit sets overflow-sticky.
- DONE (single cycle, busy still 1): on its closing edge BCD <= scratch, or all-9s (each digit 4'h9) if overflow-sticky; overflow <= sticky; blank updated; valid=1 for exactly the following cycle.
- Latency: we at edge N -> new BCD visible and valid=1 in cycle N+BIN_W+2; busy high cycles N+1..N+BIN_W+1.
- Pending slot: we=1 while busy -> num stored in pending reg, pending flag set; further we while busy overwrite it (last value wins). At DONE exit with pending set: clear flag, load pending value, re-enter SHIFT directly; busy stays 1; valid still pulses for the finished result.
- we=1 in the same cycle as DONE counts as pending (no request lost).
- BCD, overflow, blank hold between valid pulses; they never show intermediate scratch values.
- Blank mask (BLANK_LZ=1): bit i=1 iff digit i and all higher digits are 0; bit 0 always 0. Overflow result (all 9s) gives blank=0.
- Width rule: scratch is exactly 4*DIGITS bits; no truncation of num; BIN_W=1 and DIGITS=1 legal.

Test Plan:
- Defaults, reset, we=1 num=1234 -> busy 15 cycles, valid pulse at cycle 16 after we edge, BCD=16'h1234, overflow=0, blank=4'b0000.
- num=0 -> BCD=16'h0000, blank=4'b1110; num=7 -> blank=4'b1110, BCD=16'h0007; num=9999 -> 16'h9999, overflow=0.
- num=10000 and num=16383 -> BCD=16'h9999, overflow=1, blank=0; following num=42 -> overflow=0, BCD=16'h0042, blank=4'b1100.
- we num=100, then we num=200 and num=300 while busy -> two valid pulses, BCD 16'h0100 then 16'h0300; busy stays high between; 200 never appears.
- Reset asserted 5 cycles into conversion of 5678 -> no valid, BCD=0, busy=0 next cycle; new we num=5678 converts normally.
- BIN_W=8, DIGITS=3: num=255 -> 12'h255 after 10 cycles; DIGITS=2: num=100 -> 8'h99, overflow=1.

Source files
------------

// File: rtl/bcd_display_seq.sv
// bcd_display_seq: sequential binary-to-BCD converter for the seven-segment path.
// A shift-add-3 engine converts one bit per clock. Results (BCD, overflow,
// leading-zero blank mask) are registered and change only on the cycle that
// valid pulses. One request can queue behind a running conversion.
//
// Handshake: a request is accepted on any rising edge where we=1. In IDLE it
// starts a conversion immediately. While busy=1 it is parked in a one-deep
// pending slot, and the last value written wins. valid is a one-cycle pulse
// that is not backpressured. The consumer must take BCD/overflow/blank in
// that cycle or rely on them holding until the next pulse.
module bcd_display_seq #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [BIN_W-1:0]      num,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank,
    output logic [1:0]            state_dbg
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // At reset only the units digit is shown, so every higher digit is blanked.
    localparam logic [DIGITS-1:0] BLANK_RST =
        (BLANK_LZ != 0) ? ({DIGITS{1'b1}} ^ DIGITS'(1)) : '0;

    logic [1:0]        state;
    logic [BIN_W-1:0]  shift_q;
    logic [SW-1:0]     scratch_q;
    logic              sticky_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pend_q;
    logic [BIN_W-1:0]  pend_val_q;

    logic [SW-1:0]     adj;
    logic              carry;
    logic [SW-1:0]     scratch_shifted;
    logic [DIGITS-1:0] blank_next;
    logic              all_zero;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Add-3 correction on every digit >= 5, then shift one bit in from the binary register.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        carry           = adj[SW-1];
        scratch_shifted = {adj[SW-2:0], shift_q[BIN_W-1]};
    end

    // Leading-zero mask. Bit i is set when digit i and every higher digit are zero. The units digit is never blanked.
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero      = all_zero & (scratch_q[4*i +: 4] == 4'd0);
            blank_next[i] = all_zero;
        end
        blank_next[0] = 1'b0;
        if ((BLANK_LZ == 0) || sticky_q) begin
            blank_next = '0;
        end
    end

    // Conversion FSM, pending slot and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            BCD        <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            blank      <= BLANK_RST;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (we) begin
                        shift_q   <= num;
                        scratch_q <= '0;
                        sticky_q  <= 1'b0;
                        cnt_q     <= CNT_W'(BIN_W);
                        state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    scratch_q <= scratch_shifted;
                    shift_q   <= shift_q << 1;
                    sticky_q  <= sticky_q | carry;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                    if (we) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= num;
                    end
                end

                S_DONE: begin
                    valid    <= 1'b1;
                    BCD      <= sticky_q ? {DIGITS{4'h9}} : scratch_q;
                    overflow <= sticky_q;
                    blank    <= blank_next;
                    // A request arriving in this cycle is newer than any parked one.
                    if (we || pend_q) begin
                        shift_q   <= we ? num : pend_val_q;
                        scratch_q <= '0;
                        sticky_q  <= 1'b0;
                        cnt_q     <= CNT_W'(BIN_W);
                        pend_q    <= 1'b0;
                        state     <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_seq.sv
// Bench for bcd_display_seq: default 14-bit/4-digit instance plus two
// narrow instances (8-bit/3-digit and 8-bit/2-digit).
module tb_bcd_display_seq;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // main instance
  logic        we;
  logic [13:0] num;
  logic [15:0] bcd;
  logic        busy, valid, ovf;
  logic [3:0]  blank;
  logic [1:0]  state_dbg;

  // narrow instances share one request port
  logic        we_s;
  logic [7:0]  num_s;
  logic [11:0] s3_bcd;
  logic        s3_busy, s3_valid, s3_ovf;
  logic [2:0]  s3_blank;
  logic [1:0]  s3_state;
  logic [7:0]  s2_bcd;
  logic        s2_busy, s2_valid, s2_ovf;
  logic [1:0]  s2_blank;
  logic [1:0]  s2_state;

  bcd_display_seq u_dut (
    .clock(clock), .reset(reset), .we(we), .num(num),
    .BCD(bcd), .busy(busy), .valid(valid), .overflow(ovf),
    .blank(blank), .state_dbg(state_dbg)
  );

  bcd_display_seq #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1)) u_s3 (
    .clock(clock), .reset(reset), .we(we_s), .num(num_s),
    .BCD(s3_bcd), .busy(s3_busy), .valid(s3_valid), .overflow(s3_ovf),
    .blank(s3_blank), .state_dbg(s3_state)
  );

  bcd_display_seq #(.BIN_W(8), .DIGITS(2), .BLANK_LZ(1)) u_s2 (
    .clock(clock), .reset(reset), .we(we_s), .num(num_s),
    .BCD(s2_bcd), .busy(s2_busy), .valid(s2_valid), .overflow(s2_ovf),
    .blank(s2_blank), .state_dbg(s2_state)
  );

  // ---------------- scoreboard ----------------
  localparam int W = 21;  // {overflow, blank[3:0], bcd[15:0]}
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_count = 0;

  function automatic logic [W-1:0] model(input int n);
    logic [15:0] b;
    logic [3:0]  bl;
    logic        o;
    int          d;
    if (n > 9999) begin
      b  = 16'h9999;
      bl = 4'b0000;
      o  = 1'b1;
    end else begin
      o = 1'b0;
      d = n;
      for (int i = 0; i < 4; i++) begin
        b[4*i +: 4] = 4'(d % 10);
        d = d / 10;
      end
      bl[0] = 1'b0;
      bl[1] = (n < 10);
      bl[2] = (n < 100);
      bl[3] = (n < 1000);
    end
    return {o, bl, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops one expected result on every valid pulse of the main instance.
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (!reset && valid) begin
      valid_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_valid: observed=%0h expected=none", {ovf, blank, bcd});
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'({ovf, blank, bcd}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [13:0] n, input bit expect_out);
    @(negedge clock);
    we  = 1'b1;
    num = n;
    if (expect_out) exp_q.push_back(model(int'(n)));
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !busy && !valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run_small(input logic [7:0] n,
                           input logic [11:0] e3_bcd, input logic e3_ovf, input logic [2:0] e3_blank,
                           input logic [7:0] e2_bcd, input logic e2_ovf, input logic [1:0] e2_blank);
    int lat;
    @(negedge clock);
    we_s  = 1'b1;
    num_s = n;
    @(negedge clock);
    we_s = 1'b0;
    lat = 1;
    while (!s3_valid && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    check("s3_latency", 32'(lat), 32'd10);
    check("s3_bcd", 32'(s3_bcd), 32'(e3_bcd));
    check("s3_ovf", 32'(s3_ovf), 32'(e3_ovf));
    check("s3_blank", 32'(s3_blank), 32'(e3_blank));
    check("s2_valid", 32'(s2_valid), 32'd1);
    check("s2_bcd", 32'(s2_bcd), 32'(e2_bcd));
    check("s2_ovf", 32'(s2_ovf), 32'(e2_ovf));
    check("s2_blank", 32'(s2_blank), 32'(e2_blank));
    @(negedge clock);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int busy_cycles;
    int valid_at;
    int hold_bad;
    int v0;

    reset = 1'b1;
    we    = 1'b0;
    num   = '0;
    we_s  = 1'b0;
    num_s = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // reset state
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_blank", 32'(blank), 32'b1110);
    check("rst_s3_blank", 32'(s3_blank), 32'b110);
    check("rst_s2_blank", 32'(s2_blank), 32'b10);

    // 1234: busy for 15 cycles, valid in cycle 16 after the we edge, BCD holds meanwhile
    send(14'd1234, 1'b1);
    busy_cycles = 0;
    valid_at    = 0;
    hold_bad    = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_cycles++;
      if (valid && valid_at == 0) valid_at = k;
      if (busy && bcd != 16'h0) hold_bad++;
      @(negedge clock);
    end
    check("lat_busy_cycles", 32'(busy_cycles), 32'd15);
    check("lat_valid_cycle", 32'(valid_at), 32'd16);
    check("hold_during_busy", 32'(hold_bad), 32'd0);
    wait_idle();

    // value patterns, including saturation and recovery
    send(14'd0, 1'b1);     wait_idle();
    send(14'd7, 1'b1);     wait_idle();
    send(14'd9999, 1'b1);  wait_idle();
    send(14'd10000, 1'b1); wait_idle();
    send(14'd16383, 1'b1); wait_idle();
    send(14'd42, 1'b1);    wait_idle();
    repeat (5) @(negedge clock);
    check("hold_after_valid", 32'(bcd), 32'h0042);

    // pending slot: last request while busy wins, 200 must never appear
    v0 = valid_count;
    send(14'd100, 1'b1);
    send(14'd200, 1'b0);
    send(14'd300, 1'b1);
    wait_valid();
    check("pend_busy_at_valid", 32'(busy), 32'd1);
    @(negedge clock);
    wait_idle();
    check("pend_valid_pulses", 32'(valid_count - v0), 32'd2);

    // request arriving in the DONE cycle is queued, not lost
    v0 = valid_count;
    send(14'd555, 1'b1);
    repeat (13) @(negedge clock);
    send(14'd777, 1'b1);
    wait_valid();
    check("done_we_busy_at_valid", 32'(busy), 32'd1);
    @(negedge clock);
    wait_idle();
    check("done_we_valid_pulses", 32'(valid_count - v0), 32'd2);

    // reset 5 cycles into a conversion aborts it
    send(14'd5678, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_blank", 32'(blank), 32'b1110);
    v0 = valid_count;
    repeat (25) @(negedge clock);
    check("abort_no_valid", 32'(valid_count - v0), 32'd0);
    send(14'd5678, 1'b1);
    wait_idle();

    // narrow instances
    run_small(8'd255, 12'h255, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00);
    run_small(8'd100, 12'h100, 1'b0, 3'b000, 8'h99, 1'b1, 2'b00);
    run_small(8'd5,   12'h005, 1'b0, 3'b110, 8'h05, 1'b0, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
